playfield_horizontal_shifter: RTL and testbench
===============================================

Name: playfield_horizontal_shifter

Overview:
- Downstream of the playfield vertical scroll stage, which supplies the picture/ROM row selection and the per-tile horizontal flip.
- Holds the playfield horizontal scroll, counts pixel position across the line, and requests one graphics-ROM tile row per 8 pixels.
- Serialises each returned row into per-pixel colour indices for the video mixer, honouring fine scroll and PFHFLIP.

Parameters:
BPP, 4, bits per pixel
TILE_W, 8, pixels per tile row (fixed at 8; hcnt[2:0] is the pixel index)

Ports:
clk  in  1  pixel clock
clr  in  1  asynchronous active-low reset
HSCRLD  in  1  load horizontal scroll register from VBD[8:0]
VBD  in  16  video bus data
HDL  in  1  line-start strobe, one clk wide
HBLANK  in  1  horizontal blank, high = blank
PD  in  BPP*8  ROM tile-row data; valid exactly 1 clk after the matching PFLD
PFHFLIP  in  1  flip for the tile row; valid alongside PD
PFCOL  in  4  palette bank for the tile row; valid alongside PD
PFLD  out  1  tile-row fetch request
PH  out  6  tile column of the request; valid while PFLD=1
PFPIX  out  BPP  pixel colour index
PFCB  out  4  pixel palette bank
PFV  out  1  pixel valid

Behaviour:
Reset (clr=0):
- hscroll=0, hcnt=0, state=IDLE.
- PFLD=0, PH=0, PFPIX=0, PFCB=0, PFV=0.
- cur (tile data, flip and bank) cleared to 0.

Scroll register:
- HSCRLD=1 at a clk edge loads hscroll<=VBD[8:0]. Takes effect at the next line start only.

Counter:
- hcnt is 9 bits.
- HDL edge loads hcnt<=hscroll. hcnt holds through FETCH and CAPT.
- hcnt increments once per RUN cycle and wraps 511->0.

States:
- IDLE: PFV=0 and PFPIX=0 at the next edge. HDL -> FETCH.
- FETCH: PFLD=1, PH=hcnt[8:3]. Go to CAPT.
- CAPT: at the edge, cur<={PD,PFHFLIP,PFCOL}. If hcnt[2:0]==7, also PFLD=1 with PH=hcnt[8:3]+1 (mod 64). Go to RUN.
- RUN:
  - Each edge registers PFPIX<=pixel(cur,idx), PFCB<=cur bank and PFV<=1.
  - idx = hcnt[2:0], or 7-hcnt[2:0] if cur flip is set.
  - pixel i = PD[BPP*(7-i) +: BPP]; pixel 0 is leftmost, in the MSBs.
  - When next hcnt[2:0]==7 (current ==6), PFLD=1 with PH=hcnt[8:3]+1 (mod 64).
  - In the cycle hcnt[2:0]==7, cur<=returned PD/flip/bank at the edge.
  - HBLANK=1 -> IDLE.

Latency:
- HDL sampled at edge E0 gives FETCH E0..E1, CAPT E1..E2, RUN from E2.
- First valid pixel (PFV=1) appears after E3 and shows hscroll pixel hscroll[2:0].

Boundary cases:
- HDL in any state restarts at FETCH. HDL takes priority over HBLANK.
- HSCRLD with HDL on the same edge: HDL uses the old hscroll.
- HBLANK during FETCH/CAPT: ignored until RUN.
- PH wraps 63->0.
- ROM is fully pipelined: back-to-back PFLD in CAPT and the first RUN cycle is legal.
- Reset mid-line: all outputs go to 0 immediately (async), and state returns to IDLE.

Optional Feature:
- Macro: PF_TRANSPARENT_EN.
- Defined: adds output PFOPQ (1 bit), registered with PFPIX.
  - PFOPQ = PFV & (pixel != 0).
  - PFOPQ = 0 in reset and IDLE.
- Undefined: no PFOPQ port; the mixer treats every valid pixel as opaque.

Test Plan:
- Reset: clr=0 mid-RUN -> PFV, PFLD, PFPIX, PH all 0 without waiting for a clock edge; after release, state=IDLE.
- Zero scroll, hscroll=0:
  - HDL -> PFLD with PH=0, then with PD=32'h01234567, PFPIX sequence 0..7 from the 4th edge.
  - Next PFLD with PH=1 is issued when hcnt=6.
- Fine scroll and flip, hscroll=9'h00B:
  - Request PH=1; first PFPIX = pixel 3; PFLD for PH=2 when hcnt=14.
  - With PFHFLIP=1 and PD=32'h01234567, pixels run 4,3,2,1,0 and then the next tile.
- Fine scroll 7, hscroll=9'h1FF:
  - PFLD in FETCH (PH=63) and CAPT (PH=0) back to back.
  - Output is one pixel of tile 63, then tile 0; hcnt wraps to 0.
- Collision and blank:
  - HSCRLD with VBD=16'h0010 on the same edge as HDL -> PH uses the old scroll; the following line uses PH=2.
  - HBLANK=1 in RUN -> PFV=0 after the next edge.
- PF_TRANSPARENT_EN: pixel values 0,5 -> PFOPQ 0,1; PFOPQ stays 0 while PFV=0.

Source files
------------

// File: rtl/playfield_horizontal_shifter.sv
// Playfield horizontal shifter: holds fine/coarse H scroll, fetches one ROM tile row per 8 pixels
// and serialises it to colour indices. Define PF_TRANSPARENT_EN to add the PFOPQ opacity output.
module playfield_horizontal_shifter #(
  parameter int BPP    = 4,
  parameter int TILE_W = 8
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  HSCRLD,
  input  logic [15:0]           VBD,
  input  logic                  HDL,
  input  logic                  HBLANK,
  input  logic [BPP*TILE_W-1:0] PD,
  input  logic                  PFHFLIP,
  input  logic [3:0]            PFCOL,
  output logic                  PFLD,
  output logic [5:0]            PH,
  output logic [BPP-1:0]        PFPIX,
  output logic [3:0]            PFCB,
`ifdef PF_TRANSPARENT_EN
  output logic                  PFOPQ,
`endif
  output logic                  PFV
);

  typedef enum logic [1:0] {IDLE, FETCH, CAPT, RUN} state_t;

  localparam logic [2:0] LAST_PIX = 3'(TILE_W - 1);
  localparam logic [2:0] PREV_PIX = 3'(TILE_W - 2);

  state_t                  state_q, state_d;
  logic [8:0]              hscroll_q, hscroll_d;
  logic [8:0]              hcnt_q, hcnt_d;
  logic [BPP*TILE_W-1:0]   cur_pd_q, cur_pd_d;
  logic                    cur_flip_q, cur_flip_d;
  logic [3:0]              cur_col_q, cur_col_d;
  logic [BPP-1:0]          pfpix_q, pfpix_d;
  logic [3:0]              pfcb_q, pfcb_d;
  logic                    pfv_q, pfv_d;
  logic                    pfopq_q, pfopq_d;
  logic                    pfld_c;
  logic [5:0]              ph_c;
  logic [2:0]              pix_idx;
  logic [BPP-1:0]          pix_val;
  logic [BPP-1:0]          tile_pix [TILE_W];
  logic                    unused_vbd;

  assign unused_vbd = ^VBD[15:9];

  // Pixel 0 is the leftmost and sits in the most significant nibble of the row.
  for (genvar gi = 0; gi < TILE_W; gi++) begin : g_unpack
    assign tile_pix[gi] = cur_pd_q[BPP*(TILE_W-1-gi) +: BPP];
  end

  assign pix_idx = cur_flip_q ? ~hcnt_q[2:0] : hcnt_q[2:0];
  assign pix_val = tile_pix[pix_idx];

  always_comb begin
    state_d    = state_q;
    hscroll_d  = hscroll_q;
    hcnt_d     = hcnt_q;
    cur_pd_d   = cur_pd_q;
    cur_flip_d = cur_flip_q;
    cur_col_d  = cur_col_q;
    pfpix_d    = '0;
    pfcb_d     = '0;
    pfv_d      = 1'b0;
    pfopq_d    = 1'b0;
    pfld_c     = 1'b0;
    ph_c       = '0;

    if (HSCRLD) hscroll_d = VBD[8:0];

    unique case (state_q)
      IDLE: ;
      FETCH: begin
        pfld_c  = 1'b1;
        ph_c    = hcnt_q[8:3];
        state_d = CAPT;
      end
      CAPT: begin
        cur_pd_d   = PD;
        cur_flip_d = PFHFLIP;
        cur_col_d  = PFCOL;
        // Fine scroll 7 needs the next tile on the very first RUN cycle.
        if (hcnt_q[2:0] == LAST_PIX) begin
          pfld_c = 1'b1;
          ph_c   = hcnt_q[8:3] + 6'd1;
        end
        state_d = RUN;
      end
      RUN: begin
        hcnt_d = hcnt_q + 9'd1;
        if (HBLANK) begin
          state_d = IDLE;
        end else begin
          pfpix_d = pix_val;
          pfcb_d  = cur_col_q;
          pfv_d   = 1'b1;
          pfopq_d = (pix_val != '0);
        end
        if (hcnt_q[2:0] == PREV_PIX) begin
          pfld_c = 1'b1;
          ph_c   = hcnt_q[8:3] + 6'd1;
        end
        if (hcnt_q[2:0] == LAST_PIX) begin
          cur_pd_d   = PD;
          cur_flip_d = PFHFLIP;
          cur_col_d  = PFCOL;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line start wins over everything and uses the scroll value held before this edge.
    if (HDL) begin
      state_d = FETCH;
      hcnt_d  = hscroll_q;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= IDLE;
      hscroll_q  <= '0;
      hcnt_q     <= '0;
      cur_pd_q   <= '0;
      cur_flip_q <= 1'b0;
      cur_col_q  <= '0;
      pfpix_q    <= '0;
      pfcb_q     <= '0;
      pfv_q      <= 1'b0;
      pfopq_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hscroll_q  <= hscroll_d;
      hcnt_q     <= hcnt_d;
      cur_pd_q   <= cur_pd_d;
      cur_flip_q <= cur_flip_d;
      cur_col_q  <= cur_col_d;
      pfpix_q    <= pfpix_d;
      pfcb_q     <= pfcb_d;
      pfv_q      <= pfv_d;
      pfopq_q    <= pfopq_d;
    end
  end

  assign PFLD  = pfld_c;
  assign PH    = ph_c;
  assign PFPIX = pfpix_q;
  assign PFCB  = pfcb_q;
  assign PFV   = pfv_q;
`ifdef PF_TRANSPARENT_EN
  assign PFOPQ = pfopq_q;
`else
  logic unused_opq;
  assign unused_opq = pfopq_q;
`endif

endmodule

// File: tb/tb_playfield_horizontal_shifter.sv
// Scoreboard bench for playfield_horizontal_shifter: expected fetch columns and pixels are queued
// by the stimulus, and a monitor pops and compares them whenever PFLD or PFV is high.
module tb_playfield_horizontal_shifter;

  logic        clk = 1'b0;
  logic        clr;
  logic        HSCRLD;
  logic [15:0] VBD;
  logic        HDL;
  logic        HBLANK;
  logic [31:0] PD;
  logic        PFHFLIP;
  logic [3:0]  PFCOL;
  logic        PFLD;
  logic [5:0]  PH;
  logic [3:0]  PFPIX;
  logic [3:0]  PFCB;
  logic        PFV;
`ifdef PF_TRANSPARENT_EN
  logic        PFOPQ;
`endif

  logic [31:0] rom_pd [64];
  logic        rom_fl [64];
  logic [3:0]  rom_bk [64];

  int          ph_q[$];
  logic [7:0]  pix_q[$];
  int          n_pass  = 0;
  int          n_total = 0;

  playfield_horizontal_shifter #(.BPP(4), .TILE_W(8)) dut (
    .clk     (clk),
    .clr     (clr),
    .HSCRLD  (HSCRLD),
    .VBD     (VBD),
    .HDL     (HDL),
    .HBLANK  (HBLANK),
    .PD      (PD),
    .PFHFLIP (PFHFLIP),
    .PFCOL   (PFCOL),
    .PFLD    (PFLD),
    .PH      (PH),
    .PFPIX   (PFPIX),
    .PFCB    (PFCB),
`ifdef PF_TRANSPARENT_EN
    .PFOPQ   (PFOPQ),
`endif
    .PFV     (PFV)
  );

  always #5 clk = ~clk;

  // Pipelined ROM: data for the column requested in one cycle is present throughout the next.
  always @(posedge clk) begin
    if (PFLD) begin
      PD      <= rom_pd[PH];
      PFHFLIP <= rom_fl[PH];
      PFCOL   <= rom_bk[PH];
    end else begin
      PD      <= 32'hDEADBEEF;
      PFHFLIP <= 1'b1;
      PFCOL   <= 4'hE;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
      $display("check %-18s got 0x%0h expected 0x%0h ok", name, act, exp);
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_seq(input logic [3:0] bank, input int first, input int count, input int step);
    for (int i = 0; i < count; i++) pix_q.push_back({bank, 4'(first + i*step)});
  endtask

  task automatic set_rom(input int col, input logic [31:0] data, input logic fl, input logic [3:0] bk);
    rom_pd[col] = data;
    rom_fl[col] = fl;
    rom_bk[col] = bk;
  endtask

  task automatic load_scroll(input logic [15:0] v);
    @(negedge clk);
    HSCRLD = 1'b1;
    VBD    = v;
    @(negedge clk);
    HSCRLD = 1'b0;
  endtask

  // One line: HDL (optionally with a same-edge scroll load), n_pix visible pixels, then HBLANK.
  task automatic run_line(input int n_pix, input logic ld, input logic [15:0] v);
    @(negedge clk);
    HDL = 1'b1;
    if (ld) begin
      HSCRLD = 1'b1;
      VBD    = v;
    end
    @(negedge clk);
    HDL    = 1'b0;
    HSCRLD = 1'b0;
    repeat (2 + n_pix) @(negedge clk);
    HBLANK = 1'b1;
    @(negedge clk);
    chk("pfv_after_hblank", 32'(PFV), 32'd0);
    repeat (2) @(negedge clk);
    HBLANK = 1'b0;
  endtask

  initial begin
    clr = 1'b0; HSCRLD = 1'b0; VBD = '0; HDL = 1'b0; HBLANK = 1'b0;
    for (int c = 0; c < 64; c++) set_rom(c, 32'hF00DF00D, 1'b0, 4'hF);

    fork
      forever begin
        @(negedge clk);
        if (PFLD) begin
          if (ph_q.size() == 0) chk("pfld_unexpected", 32'(PFLD), 32'd0);
          else                  chk("ph", 32'(PH), ph_q.pop_front());
        end
        if (PFV) begin
          if (pix_q.size() == 0) begin
            chk("pfv_unexpected", 32'(PFV), 32'd0);
          end else begin
            logic [7:0] e;
            e = pix_q.pop_front();
            chk("pixel_bank_idx", 32'({PFCB, PFPIX}), 32'(e));
`ifdef PF_TRANSPARENT_EN
            chk("pfopq", 32'(PFOPQ), 32'(e[3:0] != 4'h0));
`endif
          end
        end
`ifdef PF_TRANSPARENT_EN
        else chk("pfopq_invalid", 32'(PFOPQ), 32'd0);
`endif
      end
    join_none

    // Reset state after the first edge with clr low.
    repeat (2) @(negedge clk);
    chk("rst_pfld",  32'(PFLD),  32'd0);
    chk("rst_ph",    32'(PH),    32'd0);
    chk("rst_pfpix", 32'(PFPIX), 32'd0);
    chk("rst_pfcb",  32'(PFCB),  32'd0);
    chk("rst_pfv",   32'(PFV),   32'd0);
    clr = 1'b1;

    set_rom(0, 32'h01234567, 1'b0, 4'h3);
    set_rom(1, 32'h89ABCDEF, 1'b0, 4'h5);

    // Asynchronous reset while a pixel is showing and a fetch is requested (hcnt=6).
    ph_q.push_back(0);
    ph_q.push_back(1);
    exp_seq(4'h3, 0, 6, 1);
    @(negedge clk);
    HDL = 1'b1;
    @(negedge clk);
    HDL = 1'b0;
    repeat (8) @(negedge clk);
    #1 clr = 1'b0;
    #1;
    chk("async_pfv",   32'(PFV),   32'd0);
    chk("async_pfld",  32'(PFLD),  32'd0);
    chk("async_pfpix", 32'(PFPIX), 32'd0);
    chk("async_ph",    32'(PH),    32'd0);
    chk("async_pfcb",  32'(PFCB),  32'd0);
    @(negedge clk);
    clr = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_pfld", 32'(PFLD), 32'd0);
      chk("idle_pfv",  32'(PFV),  32'd0);
    end

    // Zero scroll: columns 0,1,2; pixels 0..7 then 8..F.
    ph_q.push_back(0);
    ph_q.push_back(1);
    ph_q.push_back(2);
    exp_seq(4'h3, 0, 8, 1);
    exp_seq(4'h5, 8, 8, 1);
    run_line(16, 1'b0, 16'h0);

    // Fine scroll 3 on column 1 with flip: 4,3,2,1,0 then unflipped column 2.
    load_scroll(16'h000B);
    set_rom(1, 32'h01234567, 1'b1, 4'h7);
    set_rom(2, 32'h89ABCDEF, 1'b0, 4'h2);
    set_rom(3, 32'hFEDCBA98, 1'b1, 4'h1);
    ph_q.push_back(1);
    ph_q.push_back(2);
    ph_q.push_back(3);
    exp_seq(4'h7, 4, 5, -1);
    exp_seq(4'h2, 8, 7, 1);
    run_line(12, 1'b0, 16'h0);

    // Fine scroll 7 at the end of the line: back-to-back fetch 63 then 0, hcnt wraps.
    load_scroll(16'h01FF);
    set_rom(63, 32'h0000000C, 1'b0, 4'h9);
    set_rom(0,  32'h3456789A, 1'b0, 4'h4);
    ph_q.push_back(63);
    ph_q.push_back(0);
    exp_seq(4'h9, 12, 1, 1);
    exp_seq(4'h4, 3, 5, 1);
    run_line(6, 1'b0, 16'h0);

    // Scroll load on the same edge as HDL: this line uses 0x008, the next uses 0x010.
    load_scroll(16'h0008);
    set_rom(1, 32'h50000000, 1'b0, 4'h6);
    set_rom(2, 32'h0A000000, 1'b0, 4'h8);
    ph_q.push_back(1);
    pix_q.push_back({4'h6, 4'h5});
    pix_q.push_back({4'h6, 4'h0});
    run_line(2, 1'b1, 16'h0010);
    ph_q.push_back(2);
    pix_q.push_back({4'h8, 4'h0});
    pix_q.push_back({4'h8, 4'hA});
    run_line(2, 1'b0, 16'h0);

    repeat (4) @(negedge clk);
    chk("ph_queue_drained",  32'(ph_q.size()),  32'd0);
    chk("pix_queue_drained", 32'(pix_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
